pcle_cnt_reg: RTL and testbench
===============================

PCLE_CNT_REG -- requirements
Module: pcle_cnt_reg

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits.
REQ-002 Parameter WRAP_W, default 4, width of the pending-wrap counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ld  input  1  parallel load request; highest priority.
REQ-006 d  input  WIDTH  parallel load data.
REQ-007 en  input  1  count enable.
REQ-008 inh  input  1  count inhibit; overrides en.
REQ-009 tc_ack  input  1  consumer acknowledge of wrap event.
REQ-010 q  output  WIDTH  registered counter state.
REQ-011 co  output  1  registered carry-out, one-cycle pulse.
REQ-012 tc_req  output  1  wrap-event request, high while wrap_pend nonzero.
REQ-013 wrap_pend  output  WRAP_W  count of unacknowledged wraps.

Function
REQ-014 The block SHALL define cnt_act = ~ld & en & ~inh.
REQ-015 The block SHALL compute next state: ld -> d; else cnt_act -> q+1 mod 2^WIDTH; else -> all zeros (clear-when-idle, no hold mode).
REQ-016 The block SHALL register next state into q every cycle; latency ld/en to q is one cycle.
REQ-017 The block SHALL assert co for exactly the cycle after an edge where cnt_act=1 and q=all ones; co=0 otherwise, including ld with d=all ones.
REQ-018 A wrap edge (same condition as REQ-017) SHALL increment wrap_pend; tc_ack with tc_req=1 SHALL decrement it.
REQ-019 Simultaneous wrap and accepted tc_ack SHALL leave wrap_pend unchanged.
REQ-020 wrap_pend SHALL saturate at 2^WRAP_W-1; further wraps are dropped; tc_ack at 0 is ignored.
REQ-021 tc_req SHALL equal (wrap_pend != 0), derived from the register, no combinational path from inputs.
REQ-022 The handshake FSM SHALL have states IDLE (wrap_pend=0) and PEND (wrap_pend>0); IDLE->PEND on wrap; PEND->IDLE on ack when wrap_pend=1 and no wrap.
REQ-023 ld and inh SHALL never affect wrap_pend except by suppressing cnt_act.

Reset
REQ-024 On rst=1 at a clock edge q, co, wrap_pend SHALL become 0 and FSM SHALL enter IDLE, regardless of ld/en/tc_ack.
REQ-025 Reset mid-handshake SHALL discard pending wraps; tc_req is 0 the cycle after reset.
REQ-026 First cycle after rst deasserts SHALL obey REQ-015 normally.

Structure
REQ-027 WIDTH/WRAP_W defaults and the FSM state enum SHALL live in shared package pcle_pkg.
REQ-028 Next-state and carry logic SHALL be a purely combinational sub-module pcle_next_state (inputs q, d, ld, en, inh; outputs nxt, carry); pcle_cnt_reg holds all registers and the FSM.

Verification
REQ-029 Reset, then ld=1 d=0xFE one cycle, then en=1 inh=0 three cycles -> q=0xFE,0xFF,0x00,0x01; co=1 only in the cycle q=0x00; wrap_pend=1, tc_req=1.
REQ-030 q=0x55, en=1 inh=1 -> next q=0x00, co=0; q=0x55, ld=0 en=0 -> next q=0x00.
REQ-031 q=0xFF, ld=1 d=0xFF en=1 -> q=0xFF, co=0, wrap_pend unchanged.
REQ-032 wrap_pend=2, wrap and tc_ack same edge -> wrap_pend stays 2; then tc_ack two cycles, no wraps -> 1 then 0, tc_req falls.
REQ-033 20 wraps with tc_ack=0 -> wrap_pend saturates at 15; tc_ack at 0 -> stays 0.
REQ-034 wrap_pend=3, q=0x40, rst=1 with ld=1 d=0x99 -> q=0x00, co=0, wrap_pend=0, tc_req=0.

Source files
------------

// File: rtl/pcle_pkg.sv
// Shared widths and handshake state encoding for the
// loadable wrap-counting counter.
package pcle_pkg;

   localparam int PCLE_WIDTH  = 8;
   localparam int PCLE_WRAP_W = 4;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } pcle_st_e;

endpackage

// File: rtl/pcle_next_state.sv
// Combinational next-state and carry generation.
// Idle cycles clear the counter; there is no hold mode.
module pcle_next_state
   import pcle_pkg::*;
#(
   parameter int WIDTH = PCLE_WIDTH
) (
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] d,
   input  logic             ld,
   input  logic             en,
   input  logic             inh,
   output logic [WIDTH-1:0] nxt,
   output logic             carry
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic cnt_act;

   assign cnt_act = ~ld & en & ~inh;

   always_comb begin
      nxt = '0;
      if (ld) begin
         nxt = d;
      end else if (cnt_act) begin
         nxt = q + ONE;
      end
   end

   // A load of all ones is never a wrap.
   assign carry = cnt_act & (&q);

endmodule

// File: rtl/pcle_cnt_reg.sv
// Counter register with carry pulse and a saturating
// pending-wrap counter handshaked via tc_req/tc_ack.
module pcle_cnt_reg
   import pcle_pkg::*;
#(
   parameter int WIDTH  = PCLE_WIDTH,
   parameter int WRAP_W = PCLE_WRAP_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld,
   input  logic [WIDTH-1:0]  d,
   input  logic              en,
   input  logic              inh,
   input  logic              tc_ack,
   output logic [WIDTH-1:0]  q,
   output logic              co,
   output logic              tc_req,
   output logic [WRAP_W-1:0] wrap_pend
);

   localparam logic [WRAP_W-1:0] WP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};
   localparam logic [WRAP_W-1:0] WP_MAX = '1;

   logic [WIDTH-1:0]  q_q, q_d;
   logic              co_q, co_d;
   logic [WRAP_W-1:0] wp_q, wp_d;
   pcle_st_e          st_q, st_d;
   logic              wrap;
   logic              ack_ok;

   pcle_next_state #(
      .WIDTH (WIDTH)
   ) u_nxt (
      .q     (q_q),
      .d     (d),
      .ld    (ld),
      .en    (en),
      .inh   (inh),
      .nxt   (q_d),
      .carry (wrap)
   );

   assign co_d   = wrap;
   assign ack_ok = tc_ack & (wp_q != '0);

   always_comb begin
      wp_d = wp_q;
      if (wrap && !ack_ok) begin
         if (wp_q != WP_MAX) begin
            wp_d = wp_q + WP_ONE;
         end
      end else if (ack_ok && !wrap) begin
         wp_d = wp_q - WP_ONE;
      end
   end

   always_comb begin
      st_d = st_q;
      unique case (st_q)
         ST_IDLE: begin
            if (wrap) begin
               st_d = ST_PEND;
            end
         end
         ST_PEND: begin
            if (ack_ok && !wrap && wp_q == WP_ONE) begin
               st_d = ST_IDLE;
            end
         end
         default: st_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q  <= '0;
         co_q <= 1'b0;
         wp_q <= '0;
         st_q <= ST_IDLE;
      end else begin
         q_q  <= q_d;
         co_q <= co_d;
         wp_q <= wp_d;
         st_q <= st_d;
      end
   end

   assign q         = q_q;
   assign co        = co_q;
   assign wrap_pend = wp_q;
   assign tc_req    = (wp_q != '0);

endmodule

// File: tb/tb_pcle_cnt_reg.sv
// Scoreboard bench for pcle_cnt_reg: a reference model
// pushes expected state per edge, compared after the edge.
module tb_pcle_cnt_reg;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ld  = 1'b0;
   logic [7:0] d   = 8'h00;
   logic       en  = 1'b0;
   logic       inh = 1'b0;
   logic       tc_ack = 1'b0;
   logic [7:0] q;
   logic       co;
   logic       tc_req;
   logic [3:0] wrap_pend;

   typedef struct {
      int q;
      int co;
      int req;
      int wp;
   } exp_t;

   exp_t sb[$];
   int   m_q  = 0;
   int   m_wp = 0;
   int   nvec = 0;
   int   nmis = 0;

   always #5 clk = ~clk;

   pcle_cnt_reg dut (
      .clk       (clk),
      .rst       (rst),
      .ld        (ld),
      .d         (d),
      .en        (en),
      .inh       (inh),
      .tc_ack    (tc_ack),
      .q         (q),
      .co        (co),
      .tc_req    (tc_req),
      .wrap_pend (wrap_pend)
   );

   task automatic chk(input string tag, input int obs, input int exp_v);
      nvec++;
      if (obs != exp_v) begin
         nmis++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
      end
   endtask

   task automatic step(input bit r, input bit l, input int dv,
                       input bit e, input bit ih, input bit a);
      exp_t x;
      bit   act, wr, acc;
      rst = r; ld = l; d = dv[7:0]; en = e; inh = ih; tc_ack = a;
      if (r) begin
         m_q = 0; m_wp = 0; x.co = 0;
      end else begin
         act = !l && e && !ih;
         wr  = act && (m_q == 255);
         acc = a && (m_wp > 0);
         x.co = wr ? 1 : 0;
         if (l) m_q = dv & 255;
         else if (act) m_q = (m_q + 1) % 256;
         else m_q = 0;
         if (wr && !acc && m_wp < 15) m_wp = m_wp + 1;
         else if (acc && !wr) m_wp = m_wp - 1;
      end
      x.q = m_q; x.wp = m_wp; x.req = (m_wp != 0) ? 1 : 0;
      sb.push_back(x);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("sb_empty", 1, 0);
      end else begin
         x = sb.pop_front();
         chk("q", int'(q), x.q);
         chk("co", int'(co), x.co);
         chk("tc_req", int'(tc_req), x.req);
         chk("wrap_pend", int'(wrap_pend), x.wp);
      end
   endtask

   task automatic one_wrap();
      step(0, 1, 8'hFF, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
   endtask

   initial begin
      @(posedge clk);
      #1;
      step(1, 1, 8'h33, 1, 0, 1);
      // Load FE then count through the wrap
      step(0, 1, 8'hFE, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      chk("seq_q", int'(q), 8'h01);
      chk("seq_wp", int'(wrap_pend), 1);
      // Inhibit and idle both clear
      step(0, 1, 8'h55, 0, 0, 0);
      step(0, 0, 0, 1, 1, 0);
      step(0, 1, 8'h55, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      // Load of all ones over a full counter
      step(0, 1, 8'hFF, 0, 0, 0);
      step(0, 1, 8'hFF, 1, 0, 0);
      chk("ldff_co", int'(co), 0);
      // Reach two pending, then wrap with ack
      one_wrap();
      step(0, 1, 8'hFF, 0, 0, 0);
      step(0, 0, 0, 1, 0, 1);
      chk("wrapack_wp", int'(wrap_pend), 2);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("drain_req", int'(tc_req), 0);
      // Saturation and ack at zero
      for (int i = 0; i < 20; i++) one_wrap();
      chk("sat_wp", int'(wrap_pend), 15);
      for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 1);
      chk("zero_wp", int'(wrap_pend), 0);
      // Reset mid-handshake
      for (int i = 0; i < 3; i++) one_wrap();
      step(0, 1, 8'h40, 0, 0, 0);
      step(1, 1, 8'h99, 1, 0, 1);
      step(0, 1, 8'h10, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      // Random traffic biased toward wraps
      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, 40) == 0,
              $urandom_range(0, 3) == 0,
              ($urandom_range(0, 1) == 0) ? 8'hFF : int'($urandom_range(0, 255)),
              $urandom_range(0, 4) != 0,
              $urandom_range(0, 5) == 0,
              $urandom_range(0, 2) == 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
